// File: rtl/commit_buffer.sv
// In-order commit buffer: allocates IDs, collects writebacks, forwards them to the PRF and retires from head.
// Optional halt-on-commit support is enabled by defining COMMIT_BUFFER_HALT_EN.
module commit_buffer #(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int DATA_W = 8,
    parameter int PREG_W = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [IW-1:0]            alloc_robid,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IW-1:0]     wb_robid,
    input  logic [NUM_WB*8-1:0]      wb_flags,
    input  logic [NUM_WB*PREG_W-1:0] wb_pdst,
    input  logic [NUM_WB*PREG_W-1:0] wb_pold,
    input  logic [NUM_WB*DATA_W-1:0] wb_value,
    output logic [NUM_WB-1:0]        prf_we,
    output logic [NUM_WB*PREG_W-1:0] prf_id,
    output logic [NUM_WB*DATA_W-1:0] prf_value,
    output logic                     retire_valid,
    output logic [PREG_W-1:0]        retire_preg,
    output logic                     branch_valid,
    output logic                     branch_not_taken,
    output logic [DATA_W-1:0]        branch_pc,
    output logic                     flush,
    output logic                     halted,
    output logic [IW:0]              count
);
    logic [IW-1:0]     wb_id  [NUM_WB];
    logic [7:0]        wb_fl  [NUM_WB];
    logic [PREG_W-1:0] wb_pd  [NUM_WB];
    logic [PREG_W-1:0] wb_po  [NUM_WB];
    logic [DATA_W-1:0] wb_val [NUM_WB];

    for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_ch
        assign wb_id[gi]  = wb_robid[gi*IW +: IW];
        assign wb_fl[gi]  = wb_flags[gi*8 +: 8];
        assign wb_pd[gi]  = wb_pdst[gi*PREG_W +: PREG_W];
        assign wb_po[gi]  = wb_pold[gi*PREG_W +: PREG_W];
        assign wb_val[gi] = wb_value[gi*DATA_W +: DATA_W];
    end

    // Only NO_PRF_WRITE, NOT_TAKEN, HALT and BRANCH carry meaning.
    logic unused_wb_flags;
    assign unused_wb_flags = ^wb_flags;

    logic [DEPTH-1:0]  valid_q, valid_d, ready_q, ready_d;
    logic [DEPTH-1:0]  nopw_q, nopw_d, nt_q, nt_d, br_q, br_d;
`ifdef COMMIT_BUFFER_HALT_EN
    logic [DEPTH-1:0]  halt_q, halt_d;
`endif
    logic [PREG_W-1:0] pold_q  [DEPTH];
    logic [PREG_W-1:0] pold_d  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [IW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [IW:0]       count_q, count_d;

    logic [NUM_WB-1:0]        prf_we_q, prf_we_d;
    logic [NUM_WB*PREG_W-1:0] prf_id_q, prf_id_d;
    logic [NUM_WB*DATA_W-1:0] prf_value_q, prf_value_d;
    logic                     retire_valid_q, retire_valid_d;
    logic [PREG_W-1:0]        retire_preg_q, retire_preg_d;
    logic                     branch_valid_q, branch_valid_d;
    logic                     branch_nt_q, branch_nt_d;
    logic [DATA_W-1:0]        branch_pc_q, branch_pc_d;
    logic                     flush_q, flush_d;
    logic                     halted_q, halted_d;
    logic                     do_alloc, do_commit;

    assign alloc_ready = (count_q != (IW+1)'(DEPTH));
    assign alloc_robid = tail_q;
    assign do_alloc    = alloc_valid && alloc_ready;
`ifdef COMMIT_BUFFER_HALT_EN
    assign do_commit   = (count_q != '0) && ready_q[head_q] && !halted_q;
`else
    assign do_commit   = (count_q != '0) && ready_q[head_q];
`endif

    always_comb begin
        valid_d        = valid_q;
        ready_d        = ready_q;
        nopw_d         = nopw_q;
        nt_d           = nt_q;
        br_d           = br_q;
`ifdef COMMIT_BUFFER_HALT_EN
        halt_d         = halt_q;
`endif
        pold_d         = pold_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
        prf_we_d       = '0;
        prf_id_d       = prf_id_q;
        prf_value_d    = prf_value_q;
        retire_valid_d = 1'b0;
        retire_preg_d  = retire_preg_q;
        branch_valid_d = 1'b0;
        branch_nt_d    = branch_nt_q;
        branch_pc_d    = branch_pc_q;
        flush_d        = 1'b0;
        halted_d       = halted_q;

        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && valid_q[wb_id[i]]) begin
                ready_d[wb_id[i]] = 1'b1;
                nopw_d[wb_id[i]]  = wb_fl[i][7];
                nt_d[wb_id[i]]    = wb_fl[i][5];
                br_d[wb_id[i]]    = wb_fl[i][0];
`ifdef COMMIT_BUFFER_HALT_EN
                halt_d[wb_id[i]]  = wb_fl[i][4];
`endif
                pold_d[wb_id[i]]  = wb_po[i];
                value_d[wb_id[i]] = wb_val[i];
                if (!wb_fl[i][7]) begin
                    prf_we_d[i]                       = 1'b1;
                    prf_id_d[i*PREG_W +: PREG_W]      = wb_pd[i];
                    prf_value_d[i*DATA_W +: DATA_W]   = wb_val[i];
                end
            end
        end

        if (do_alloc) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + 1'b1;
        end

        if (do_commit) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            if (!nopw_q[head_q]) begin
                retire_valid_d = 1'b1;
                retire_preg_d  = pold_q[head_q];
            end
            if (br_q[head_q]) begin
                branch_valid_d = 1'b1;
                branch_nt_d    = nt_q[head_q];
                branch_pc_d    = value_q[head_q];
                // Taken branch: everything younger is wrong-path, including this cycle's alloc/wb.
                if (!nt_q[head_q]) begin
                    valid_d = '0;
                    ready_d = '0;
                    tail_d  = head_q + 1'b1;
                    count_d = '0;
                    flush_d = 1'b1;
                end
            end
`ifdef COMMIT_BUFFER_HALT_EN
            if (halt_q[head_q]) halted_d = 1'b1;
`endif
        end
`ifndef COMMIT_BUFFER_HALT_EN
        halted_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            ready_q        <= '0;
            nopw_q         <= '0;
            nt_q           <= '0;
            br_q           <= '0;
`ifdef COMMIT_BUFFER_HALT_EN
            halt_q         <= '0;
`endif
            for (int k = 0; k < DEPTH; k++) begin
                pold_q[k]  <= '0;
                value_q[k] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            prf_we_q       <= '0;
            prf_id_q       <= '0;
            prf_value_q    <= '0;
            retire_valid_q <= 1'b0;
            retire_preg_q  <= '0;
            branch_valid_q <= 1'b0;
            branch_nt_q    <= 1'b0;
            branch_pc_q    <= '0;
            flush_q        <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            nopw_q         <= nopw_d;
            nt_q           <= nt_d;
            br_q           <= br_d;
`ifdef COMMIT_BUFFER_HALT_EN
            halt_q         <= halt_d;
`endif
            pold_q         <= pold_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            prf_we_q       <= prf_we_d;
            prf_id_q       <= prf_id_d;
            prf_value_q    <= prf_value_d;
            retire_valid_q <= retire_valid_d;
            retire_preg_q  <= retire_preg_d;
            branch_valid_q <= branch_valid_d;
            branch_nt_q    <= branch_nt_d;
            branch_pc_q    <= branch_pc_d;
            flush_q        <= flush_d;
            halted_q       <= halted_d;
        end
    end

    assign prf_we           = prf_we_q;
    assign prf_id           = prf_id_q;
    assign prf_value        = prf_value_q;
    assign retire_valid     = retire_valid_q;
    assign retire_preg      = retire_preg_q;
    assign branch_valid     = branch_valid_q;
    assign branch_not_taken = branch_nt_q;
    assign branch_pc        = branch_pc_q;
    assign flush            = flush_q;
    assign halted           = halted_q;
    assign count            = count_q;
endmodule

// File: tb/tb_commit_buffer.sv
// Bench for commit_buffer: directed vector table, hand-written corner sequences and a random run
// checked against a queue-based program-order model.
module tb_commit_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [3:0]  alloc_robid;
    logic [1:0]  wb_valid = '0;
    logic [7:0]  wb_robid = '0;
    logic [15:0] wb_flags = '0;
    logic [7:0]  wb_pdst = '0;
    logic [7:0]  wb_pold = '0;
    logic [15:0] wb_value = '0;
    logic [1:0]  prf_we;
    logic [7:0]  prf_id;
    logic [15:0] prf_value;
    logic        retire_valid;
    logic [3:0]  retire_preg;
    logic        branch_valid;
    logic        branch_not_taken;
    logic [7:0]  branch_pc;
    logic        flush;
    logic        halted;
    logic [4:0]  count;

`ifdef COMMIT_BUFFER_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    commit_buffer #(.DEPTH(16), .NUM_WB(2), .DATA_W(8), .PREG_W(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_robid(alloc_robid),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_flags(wb_flags),
        .wb_pdst(wb_pdst), .wb_pold(wb_pold), .wb_value(wb_value),
        .prf_we(prf_we), .prf_id(prf_id), .prf_value(prf_value),
        .retire_valid(retire_valid), .retire_preg(retire_preg),
        .branch_valid(branch_valid), .branch_not_taken(branch_not_taken), .branch_pc(branch_pc),
        .flush(flush), .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Program-order model: the queue holds in-flight entries oldest first.
    typedef struct {
        int         id;
        bit         rdy;
        logic [7:0] fl;
        logic [3:0] pold;
        logic [7:0] val;
    } ent_t;
    ent_t       mq[$];
    int         m_next;
    bit         m_halted, m_ret, m_br, m_nt, m_flush;
    logic [3:0] m_retp;
    logic [7:0] m_bpc;
    logic [1:0] m_we;
    logic [3:0] m_pid [2];
    logic [7:0] m_pval [2];

    // Per-cycle stimulus
    logic       d_alloc;
    logic [1:0] d_wbv;
    logic [3:0] d_id [2];
    logic [7:0] d_fl [2];
    logic [3:0] d_pd [2];
    logic [3:0] d_po [2];
    logic [7:0] d_val [2];

    task automatic model_reset();
        mq.delete();
        m_next = 0; m_halted = 0; m_ret = 0; m_br = 0; m_nt = 0; m_flush = 0;
        m_retp = '0; m_bpc = '0; m_we = '0;
        for (int c = 0; c < 2; c++) begin m_pid[c] = '0; m_pval[c] = '0; end
    endtask

    task automatic model_edge();
        ent_t c;
        bit   com;
        com = (mq.size() > 0) && mq[0].rdy && !m_halted;
        if (com) c = mq[0];
        m_ret = 0; m_br = 0; m_flush = 0; m_we = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (d_wbv[ch]) begin
                foreach (mq[k]) begin
                    if (mq[k].id == int'(d_id[ch])) begin
                        mq[k].rdy = 1; mq[k].fl = d_fl[ch];
                        mq[k].pold = d_po[ch]; mq[k].val = d_val[ch];
                        if (!d_fl[ch][7]) begin
                            m_we[ch] = 1'b1; m_pid[ch] = d_pd[ch]; m_pval[ch] = d_val[ch];
                        end
                    end
                end
            end
        end
        if (d_alloc && mq.size() != 16) begin
            mq.push_back('{id: m_next, rdy: 0, fl: 8'h00, pold: 4'h0, val: 8'h00});
            m_next = (m_next + 1) % 16;
        end
        if (com) begin
            void'(mq.pop_front());
            if (!c.fl[7]) begin m_ret = 1; m_retp = c.pold; end
            if (c.fl[0]) begin
                m_br = 1; m_nt = c.fl[5]; m_bpc = c.val;
                if (!c.fl[5]) begin
                    m_flush = 1; mq.delete(); m_next = (c.id + 1) % 16;
                end
            end
            if (HALT_EN && c.fl[4]) m_halted = 1;
        end
    endtask

    task automatic compare_all();
        chk("count", count, mq.size());
        chk("retire_valid", retire_valid, m_ret);
        chk("retire_preg", retire_preg, m_retp);
        chk("branch_valid", branch_valid, m_br);
        chk("branch_not_taken", branch_not_taken, m_nt);
        chk("branch_pc", branch_pc, m_bpc);
        chk("flush", flush, m_flush);
        chk("halted", halted, m_halted);
        chk("prf_we", prf_we, m_we);
        chk("prf_id", prf_id, {m_pid[1], m_pid[0]});
        chk("prf_value", prf_value, {m_pval[1], m_pval[0]});
    endtask

    task automatic clear_drive();
        d_alloc = 0; d_wbv = '0;
        for (int c = 0; c < 2; c++) begin
            d_id[c] = '0; d_fl[c] = '0; d_pd[c] = '0; d_po[c] = '0; d_val[c] = '0;
        end
    endtask

    task automatic set_wb(input int ch, input logic [3:0] id, input logic [7:0] fl,
                          input logic [3:0] pd, input logic [3:0] po, input logic [7:0] val);
        d_wbv[ch] = 1'b1; d_id[ch] = id; d_fl[ch] = fl; d_pd[ch] = pd; d_po[ch] = po; d_val[ch] = val;
    endtask

    // Called at a negedge; drives, clocks, updates the model, checks, returns at the next negedge.
    task automatic step();
        alloc_valid = d_alloc;
        wb_valid    = d_wbv;
        for (int ch = 0; ch < 2; ch++) begin
            wb_robid[ch*4 +: 4] = d_id[ch];
            wb_flags[ch*8 +: 8] = d_fl[ch];
            wb_pdst[ch*4 +: 4]  = d_pd[ch];
            wb_pold[ch*4 +: 4]  = d_po[ch];
            wb_value[ch*8 +: 8] = d_val[ch];
        end
        #1;
        chk("alloc_ready", alloc_ready, mq.size() != 16);
        chk("alloc_robid", alloc_robid, m_next);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
        clear_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_drive();
        alloc_valid = 0; wb_valid = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare_all();
        chk("reset_alloc_ready", alloc_ready, 1);
        @(negedge clk);
    endtask

    function automatic logic [7:0] pick_flags();
        case ($urandom_range(0, 15))
            11, 12:  pick_flags = 8'h80;
            13:      pick_flags = 8'h21;
            14:      pick_flags = 8'hA1;
            15:      pick_flags = 8'h01;
            10:      pick_flags = HALT_EN ? 8'h00 : 8'h10;
            default: pick_flags = 8'h00;
        endcase
    endfunction

    typedef struct {
        logic       alloc;
        logic [1:0] wbv;
        logic [3:0] id0; logic [7:0] fl0; logic [3:0] pd0; logic [3:0] po0; logic [7:0] v0;
        logic [3:0] id1; logic [7:0] fl1; logic [3:0] pd1; logic [3:0] po1; logic [7:0] v1;
        logic [4:0] e_count; logic [1:0] e_we;
        logic e_ret; logic e_br; logic e_nt; logic e_flush;
    } vec_t;
    vec_t tv [13];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 0};
        tv[2]  = '{1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       3, 0, 0, 0, 0, 0};
        tv[3]  = '{1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       4, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 3, 3, 8'h00, 5, 1, 8'h2A, 1, 8'h00, 9, 2, 8'h11, 4, 3, 0, 0, 0, 0};
        tv[5]  = '{0, 1, 0, 8'h21, 7, 3, 8'h40, 0, 0, 0, 0, 0,       4, 1, 0, 0, 0, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       3, 0, 1, 1, 1, 0};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       2, 0, 1, 0, 1, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       2, 0, 0, 0, 1, 0};
        tv[9]  = '{0, 2, 0, 0, 0, 0, 0,       2, 8'h80, 4, 4, 8'h33, 2, 0, 0, 0, 1, 0};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       1, 0, 0, 0, 1, 0};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0};

        clear_drive();
        model_reset();
        @(negedge clk);
        do_reset();

        // Vector table: dual writeback, not-taken branch, NO_PRF_WRITE retire
        for (int i = 0; i < 13; i++) begin
            d_alloc = tv[i].alloc;
            if (tv[i].wbv[0]) set_wb(0, tv[i].id0, tv[i].fl0, tv[i].pd0, tv[i].po0, tv[i].v0);
            if (tv[i].wbv[1]) set_wb(1, tv[i].id1, tv[i].fl1, tv[i].pd1, tv[i].po1, tv[i].v1);
            step();
            chk($sformatf("vec%0d.count", i), count, tv[i].e_count);
            chk($sformatf("vec%0d.prf_we", i), prf_we, tv[i].e_we);
            chk($sformatf("vec%0d.retire_valid", i), retire_valid, tv[i].e_ret);
            chk($sformatf("vec%0d.branch_valid", i), branch_valid, tv[i].e_br);
            chk($sformatf("vec%0d.branch_not_taken", i), branch_not_taken, tv[i].e_nt);
            chk($sformatf("vec%0d.flush", i), flush, tv[i].e_flush);
            if (i == 4) begin
                chk("dual.prf_id", prf_id, 8'h95);
                chk("dual.prf_value", prf_value, 16'h112A);
            end
            if (i == 6) chk("nt.branch_pc", branch_pc, 8'h40);
        end

        // Fill and drain in ID order after reverse writeback
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk("fill.robid", alloc_robid, i);
            d_alloc = 1; step();
        end
        chk("fill.count", count, 16);
        chk("fill.alloc_ready", alloc_ready, 0);
        for (int i = 15; i >= 0; i--) begin
            set_wb(0, 4'(i), 8'h00, 4'(i), 4'(i), 8'(i)); step();
        end
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain.retire_valid", retire_valid, 1);
            chk("drain.retire_preg", retire_preg, i);
        end
        chk("drain.count", count, 0);
        chk("wrap.robid", alloc_robid, 0);

        // Full with head ready: allocation refused that cycle, accepted next
        for (int i = 0; i < 16; i++) begin d_alloc = 1; step(); end
        set_wb(0, 0, 8'h00, 1, 1, 8'h01); step();
        d_alloc = 1; step();
        chk("full.count", count, 15);
        chk("full.alloc_ready", alloc_ready, 1);
        chk("full.robid", alloc_robid, 0);
        d_alloc = 1; step();
        chk("full.refill", count, 16);

        // Taken branch flushes younger entries
        do_reset();
        d_alloc = 1; step();
        d_alloc = 1; step();
        set_wb(0, 0, 8'h00, 2, 2, 8'h02); set_wb(1, 1, 8'h00, 3, 3, 8'h03); step();
        step(); step();
        for (int i = 0; i < 5; i++) begin d_alloc = 1; step(); end
        set_wb(0, 3, 8'h00, 6, 6, 8'h06); step();
        set_wb(0, 2, 8'h81, 7, 7, 8'h80); step();
        d_alloc = 1; set_wb(1, 4, 8'h00, 8, 8, 8'h08); step();
        chk("taken.branch_pc", branch_pc, 8'h80);
        chk("taken.flush", flush, 1);
        chk("taken.retire_valid", retire_valid, 0);
        chk("taken.count", count, 0);
        chk("taken.robid", alloc_robid, 3);
        set_wb(0, 4, 8'h00, 9, 9, 8'h09); step();
        chk("stale.prf_we", prf_we, 0);
        d_alloc = 1; step();
        d_alloc = 1; step();
        set_wb(0, 3, 8'h00, 10, 10, 8'h0A); step();
        step(); step();
        chk("stale.count", count, 1);
        chk("stale.retire_valid", retire_valid, 0);

        // Halt commit, then asynchronous reset mid-stream
        do_reset();
        d_alloc = 1; step();
        d_alloc = 1; step();
        set_wb(0, 0, 8'h10, 1, 1, 8'h01); set_wb(1, 1, 8'h00, 2, 2, 8'h02); step();
        step();
        chk("halt.retire_valid", retire_valid, 1);
        chk("halt.halted", halted, HALT_EN);
        step(); step();
        chk("halt.count", count, HALT_EN ? 1 : 0);
        d_alloc = 1; step();
        set_wb(0, 4'(m_next - 1), 8'h00, 3, 3, 8'h03); step();
        chk("pre_rst.prf_we", prf_we, 1);
        rst = 1'b1;
        #1;
        chk("arst.halted", halted, 0);
        chk("arst.count", count, 0);
        chk("arst.prf_we", prf_we, 0);
        chk("arst.retire_valid", retire_valid, 0);
        chk("arst.alloc_ready", alloc_ready, 1);
        chk("arst.alloc_robid", alloc_robid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            d_alloc = ($urandom_range(0, 9) < 6);
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [3:0] id;
                    if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                        id = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
                    else
                        id = 4'($urandom_range(0, 15));
                    if (!(ch == 1 && d_wbv[0] && id == d_id[0]))
                        set_wb(ch, id, pick_flags(), 4'($urandom), 4'($urandom), 8'($urandom));
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/commit_buffer.md
# commit_buffer

Parametrised in-order commit buffer between the execution units and the PRF / free list / fetch unit. It hands out entry IDs at dispatch, collects results from `NUM_WB` writeback channels and forwards each result to the PRF one cycle later. It retires one entry per cycle from the head in program order, freeing the old physical register and redirecting fetch on branches; a committed taken branch flushes every younger entry.

## Interface
- `DEPTH`, 16: entries; power of two, at least 4. `IW = $clog2(DEPTH)`.
- `NUM_WB`, 2: writeback channels, 1–4.
- `DATA_W`, 8: result/PC width.
- `PREG_W`, 4: physical register index width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `alloc_valid` input 1: dispatch requests one entry.
- `alloc_ready` output 1: `count != DEPTH`.
- `alloc_robid` output IW: tail index.
- `wb_valid` input NUM_WB: per-channel result strobe.
- `wb_robid` input NUM_WB×IW: target entry.
- `wb_flags` input NUM_WB×8: [7] NO_PRF_WRITE, [5] NOT_TAKEN, [4] HALT, [0] BRANCH.
- `wb_pdst` input NUM_WB×PREG_W: destination preg.
- `wb_pold` input NUM_WB×PREG_W: preg to free at retire.
- `wb_value` input NUM_WB×DATA_W: result, or target PC for branches.
- `prf_we` output NUM_WB: PRF write strobe per channel.
- `prf_id` output NUM_WB×PREG_W: PRF write index.
- `prf_value` output NUM_WB×DATA_W: PRF write data.
- `retire_valid` output 1: an entry retired and frees a preg.
- `retire_preg` output PREG_W: freed preg.
- `branch_valid` output 1: a branch retired.
- `branch_not_taken` output 1: the retired branch was not taken.
- `branch_pc` output DATA_W: target PC.
- `flush` output 1: younger entries discarded.
- `halted` output 1: halt committed; sticky.
- `count` output IW+1: occupied entries.

## Operation
- State per entry: `valid`, `ready`, `flags`, `pold`, `value`. Pointers `head` and `tail` are IW bits wide and wrap modulo DEPTH.
- **Allocation:** when `alloc_valid && alloc_ready`, set `valid[tail]`, clear `ready[tail]`, and increment `tail`.
- **Full condition:** `alloc_ready` is computed from the registered `count`. When full, no allocation is accepted, even in a cycle where an entry retires.
- **Writeback, channel i:** when `wb_valid[i]` and `valid[wb_robid[i]]` are both set, store the fields and set `ready`.
  - `prf_we[i]` is set if `wb_flags[i][7]` is clear; `prf_id[i]`/`prf_value[i]` carry `wb_pdst[i]`/`wb_value[i]` (the incoming data, not stored data).
  - A writeback to an entry that is not valid is dropped, with no PRF write.
  - Two channels targeting the same robid in one cycle is illegal and is not checked.
- **Commit:** occurs when `count != 0 && ready[head]`. Clear `valid`/`ready` at `head` and increment `head`.
  - If `!flags[7]`: pulse `retire_valid` with `retire_preg = pold`.
  - If `flags[0]`: pulse `branch_valid`, with `branch_not_taken = flags[5]` and `branch_pc = value`.
  - If `flags[0] && !flags[5]`: this is a flush. Clear all `valid`/`ready` bits and set `tail <= head+1`, `count <= 0`, and pulse `flush`.
  - In a flush cycle, same-cycle allocation and writebacks are discarded; `prf_we` is still driven for those writebacks.
- **Count:** `count` changes by +alloc −commit, or is forced to 0 on flush.
- **Reset:** all outputs 0, pointers 0, all entry state cleared, `alloc_ready` = 1. Reset asserted mid-operation discards all entries immediately.

## Timing
- `alloc_robid` is combinational from `tail`; the allocation takes effect at the edge.
- Writeback at edge N: `ready` is visible after N, and the `prf_*` outputs are valid for the cycle after N.
- Commit outputs are registered. For an entry written back at edge N and already at head, the commit outputs are valid for exactly one cycle after edge N+1. Minimum writeback-to-retire latency is 2 edges.
- `retire_valid`, `branch_valid`, `flush` and `prf_we` are single-cycle pulses; the data outputs hold their last value.
- A new entry allocated into a freed slot at edge N is visible at edge N+1.

## Configuration
- `COMMIT_BUFFER_HALT_EN` defined:
  - Committing an entry with `flags[4]` retires it normally and sets `halted` at the same edge.
  - While `halted` is set, no further commits occur; allocation and writeback continue.
  - Only `rst` clears `halted`.
- `COMMIT_BUFFER_HALT_EN` undefined: `flags[4]` is ignored and `halted` is tied to 0.

## Test plan
- **Fill and drain:** DEPTH=16, 16 allocations → `alloc_ready`=0 and `count`=16. Write back all entries in reverse order → 16 retires in ID order 0..15 on consecutive cycles, then `count`=0.
- **Dual writeback:** channel 0 robid 3 `pdst`=5 `value`=0x2A and channel 1 robid 1 `pdst`=9 `value`=0x11 in the same cycle → next cycle `prf_we`=2'b11 with the matching IDs and values.
- **Branch not taken:** head entry has flags 0x21 and value 0x40 → `branch_valid`=1, `branch_not_taken`=1, `branch_pc`=0x40, `flush`=0, and younger entries remain.
- **Taken branch:** with 5 entries in flight, head has flags 0x81 and value 0x80 → `branch_pc`=0x80, `flush`=1, `retire_valid`=0, `count`=0. Next `alloc_robid` = old head+1, and a stale writeback to an old ID does not set `ready`.
- **Wrap and full-with-retire:** allocate 20 with retires interleaved → IDs wrap 15→0. When full with head ready, `alloc_valid` is not accepted that cycle and `alloc_ready`=1 the next cycle.
- **Halt and reset:** commit an entry with flags 0x10 → `halted`=1 and the following ready entry does not retire (with the macro defined); asserting `rst` mid-stream clears `halted`, `count` and all outputs asynchronously.
